mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use the following header-defined widths (name, default, meaning), one per line:
- ES_TO_MS_BUS_WD, 75, EX-to-MEM bus width.
- MS_TO_WS_BUS_WD, 70, MEM-to-WB bus width.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock; all state on rising edge.
- resetn, in, 1, asynchronous active-low reset.
- ms_allowin, out, 1, MEM can accept from EX this cycle.
- es_to_ms_valid, in, 1, EX offers an instruction.
- es_to_ms_bus, in, ES_TO_MS_BUS_WD, {load_op[74:72], addr_lo[71:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- ws_allowin, in, 1, WB can accept.
- ms_to_ws_valid, out, 1, MEM offers a completed instruction.
- ms_to_ws_bus, out, MS_TO_WS_BUS_WD, {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- data_sram_data_ok, in, 1, one-cycle pulse: load response valid.
- data_sram_rdata, in, 32, load response data, valid with data_ok.
- ms_dst_reg, out, 5, dest of the valid instruction in MEM, else 0 (hazard detection).

Function
REQ-003 load_op encoding SHALL be: 000 none, 001 LW, 010 LB, 011 LBU, 100 LH, 101 LHU; 110/111 SHALL be treated as none.
REQ-004 A non-load SHALL complete in the cycle it becomes valid: final_result = alu_result.
REQ-005 Handshake: ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-006 EX bus SHALL be registered only when es_to_ms_valid && ms_allowin.
REQ-007 ms_valid SHALL load es_to_ms_valid whenever ms_allowin is 1.
REQ-008 Load state machine: IDLE, WAIT, HOLD.
- IDLE->WAIT: a load is accepted.
- WAIT->IDLE: data_ok && ws_allowin.
- WAIT->HOLD: data_ok && !ws_allowin; rdata captured into a 32-bit buffer.
- HOLD->IDLE: ws_allowin.
REQ-009 ms_ready_go SHALL be 1 for non-loads, 1 in WAIT only while data_ok=1, 1 in HOLD.
REQ-010 Result data source SHALL be data_sram_rdata in WAIT and the buffer in HOLD.
REQ-011 A new load accepted in the same cycle the previous load leaves SHALL enter WAIT directly, with no IDLE bubble.
REQ-012 data_ok arriving in IDLE (no load pending) SHALL be ignored, with no state or output change.
REQ-013 LW SHALL pass the 32-bit word unchanged; addr_lo is ignored.
REQ-014 LB/LBU SHALL select byte addr_lo (0 = bits 7:0 … 3 = bits 31:24) and sign-/zero-extend it to 32 bits.
REQ-015 LH/LHU SHALL select the half at addr_lo[1] (0 = bits 15:0, 1 = bits 31:16) and sign-/zero-extend it; addr_lo[0] is ignored.
REQ-016 gr_we, dest and pc SHALL pass unchanged to ms_to_ws_bus.
REQ-017 ms_dst_reg = ms_valid ? dest : 5'd0.

Reset
REQ-018 resetn low SHALL asynchronously clear ms_valid, state (IDLE), the HOLD buffer and the registered bus.
REQ-019 During and after reset, until the first accepted instruction: ms_to_ws_valid=0, ms_allowin=1, ms_dst_reg=0, ms_to_ws_bus=0.
REQ-020 Reset asserted mid-load (WAIT or HOLD) SHALL discard the load; a data_ok arriving after deassertion SHALL be ignored per REQ-012.

Configuration
REQ-021 Macro MS_SUBWORD_LOAD_EN, when defined, SHALL enable REQ-014/REQ-015.
REQ-022 When MS_SUBWORD_LOAD_EN is undefined, LB/LBU/LH/LHU SHALL return the full 32-bit word as LW; timing and handshake are unchanged.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- ALU op: alu_result=0x1234_5678, dest=5, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x12345678,pc}, ms_dst_reg=5.
- LB, addr_lo=2, rdata=0x0080_0000, data_ok after 3 cycles -> ms_to_ws_valid only in the data_ok cycle; result 0xFFFF_FF80; LBU gives 0x0000_0080.
- LHU, addr_lo=2, rdata=0xBEEF_0000, data_ok while ws_allowin=0 for 2 cycles -> HOLD; ms_allowin=0; on release result 0x0000_BEEF, valid for exactly one accepted cycle.
- Back-to-back LW pair, data_ok on consecutive cycles -> both results in order, no bubble.
- Spurious data_ok in IDLE -> no output change.
- resetn pulled low in WAIT -> ms_to_ws_valid=0 immediately; a later data_ok is ignored.
- Build without MS_SUBWORD_LOAD_EN: LB, rdata=0x0080_0000 -> result 0x0080_0000.

Source files
------------

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage.
//
// Takes one instruction at a time from EX. Non-loads finish in the cycle
// they become valid. Loads wait for the data SRAM response (data_ok pulse).
// If WB is stalled when the response arrives, the response is parked in a
// 32-bit buffer until WB accepts the instruction.
//
// Optional feature (macro MS_SUBWORD_LOAD_EN):
//   defined   : LB/LBU/LH/LHU select a byte/half and sign/zero-extend it
//   undefined : every load returns the full 32-bit word, as LW does
//
// Ports:
//   clk               in   clock, all state on rising edge
//   resetn            in   asynchronous active-low reset
//   ms_allowin        out  MEM can accept from EX this cycle
//   es_to_ms_valid    in   EX offers an instruction
//   es_to_ms_bus      in   {load_op, addr_lo, gr_we, dest, alu_result, pc}
//   ws_allowin        in   WB can accept
//   ms_to_ws_valid    out  MEM offers a completed instruction
//   ms_to_ws_bus      out  {gr_we, dest, final_result, pc}
//   data_sram_data_ok in   one-cycle pulse, load response valid
//   data_sram_rdata   in   load response data
//   ms_dst_reg        out  dest of the valid instruction, else 0
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 75,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 ms_dst_reg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    // 110/111 are reserved and behave as non-loads.
    function automatic logic is_load(input logic [2:0] op);
        return (op >= OP_LW) && (op <= OP_LHU);
    endfunction

    state_e                     state_q, state_d;
    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic [31:0]                buf_q, buf_d;

    logic [2:0]  load_op;
    logic [1:0]  addr_lo;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {load_op, addr_lo, gr_we, dest, alu_result, pc} = es_bus_q;

    logic        ms_is_load;
    logic        ms_ready_go;
    logic        accept;
    logic [31:0] raw_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_is_load = is_load(load_op);

    always_comb begin
        if (!ms_is_load) begin
            ms_ready_go = 1'b1;
        end else begin
            unique case (state_q)
                S_WAIT:  ms_ready_go = data_sram_data_ok;
                S_HOLD:  ms_ready_go = 1'b1;
                default: ms_ready_go = 1'b0;
            endcase
        end
    end

    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;
    assign ms_dst_reg     = ms_valid_q ? dest : 5'd0;

    // Next-state logic. Whenever MEM can take a new instruction the old one
    // is leaving (or MEM was empty), so the state is decided purely by what
    // enters: an accepted load goes straight to WAIT with no IDLE bubble.
    // data_ok outside WAIT never changes anything.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        buf_d   = buf_q;
        if (ms_allowin) begin
            state_d = (accept && is_load(es_to_ms_bus[74:72])) ? S_WAIT : S_IDLE;
        end else if (state_q == S_WAIT && data_sram_data_ok) begin
            state_d = S_HOLD;
            buf_d   = data_sram_rdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ms_valid_q <= 1'b0;
            es_bus_q   <= '0;
            // NOTE: the buffer is a single word, cheap to reset, and clearing
            // it keeps ms_to_ws_bus at zero until the first instruction.
            buf_q      <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (accept) begin
                es_bus_q <= es_to_ms_bus;
            end
        end
    end

    // Outside WAIT the buffer is the source, so a stray data_ok while idle
    // cannot disturb the output bus.
    assign raw_word = (state_q == S_WAIT) ? data_sram_rdata : buf_q;

`ifdef MS_SUBWORD_LOAD_EN
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        unique case (addr_lo)
            2'd0:    sel_byte = raw_word[7:0];
            2'd1:    sel_byte = raw_word[15:8];
            2'd2:    sel_byte = raw_word[23:16];
            default: sel_byte = raw_word[31:24];
        endcase
        sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        unique case (load_op)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'd0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'd0, sel_half};
            default: load_data = raw_word;
        endcase
    end
`else
    // Without sub-word support every load is a full word; the byte offset
    // is deliberately unused in this build.
    assign load_data = raw_word;
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_lo;
`endif

    assign final_result = ms_is_load ? load_data : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Expected WB-bus words are queued as instructions are driven and compared
// when MEM hands an instruction to WB. Compile with +define+MS_SUBWORD_LOAD_EN
// to exercise the sub-word build; expectations follow the same macro.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [4:0]  ms_dst_reg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [69:0] sb_q[$];

    mem_stage #(.ES_TO_MS_BUS_WD(75), .MS_TO_WS_BUS_WD(70)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .ms_dst_reg       (ms_dst_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] w);
`ifdef MS_SUBWORD_LOAD_EN
        logic [7:0]  b;
        logic [15:0] h;
        b = w[lo*8 +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (op)
            3'd2:    return {{24{b[7]}}, b};
            3'd3:    return {24'd0, b};
            3'd4:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
`else
        return (op == 3'd0) ? 32'hx : w;
`endif
    endfunction

    // Scoreboard: every instruction handed to WB is compared with the queue.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", ms_to_ws_valid, 1'b0);
            end else begin
                check("wb_bus", ms_to_ws_bus, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction and hold it until MEM accepts it; returns one
    // step after the accepting edge, with the instruction now inside MEM.
    task automatic send(input logic [2:0] op, input logic [1:0] lo, input logic we,
                        input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc);
        logic ok;
        ok = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {op, lo, we, dst, alu, pc};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ms_allowin) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", ok, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    // Load already in WAIT: wait `delay` cycles, then pulse data_ok.
    task automatic load_resp(input int delay, input logic [31:0] word);
        for (int i = 0; i < delay; i++) begin
            check("wait_no_valid", ms_to_ws_valid, 1'b0);
            check("wait_no_allowin", ms_allowin, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = word;
        #1;
        check("dataok_valid", ms_to_ws_valid, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5A5A_A5A5;
        check("after_load_valid", ms_to_ws_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", ms_to_ws_valid, 1'b0);
        check("rst_allowin", ms_allowin, 1'b1);
        check("rst_dst", ms_dst_reg, 5'd0);
        check("rst_bus", ms_to_ws_bus, 70'd0);
        resetn = 1'b1;
        tick();
        check("post_rst_bus", ms_to_ws_bus, 70'd0);

        // ALU op completes the cycle it becomes valid
        sb_q.push_back({1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000});
        send(3'd0, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000);
        check("alu_valid", ms_to_ws_valid, 1'b1);
        check("alu_dst", ms_dst_reg, 5'd5);
        tick();
        check("alu_gone_valid", ms_to_ws_valid, 1'b0);
        check("alu_gone_dst", ms_dst_reg, 5'd0);

        // Reserved load_op 110 behaves as a non-load
        sb_q.push_back({1'b1, 5'd9, 32'hCAFE_0001, 32'h0000_1004});
        send(3'd6, 2'd1, 1'b1, 5'd9, 32'hCAFE_0001, 32'h0000_1004);
        check("rsv_valid", ms_to_ws_valid, 1'b1);
        tick();

        // LB / LBU, data_ok three cycles after entry
        sb_q.push_back({1'b1, 5'd7, exp_load(3'd2, 2'd2, 32'h0080_0000), 32'h0000_2000});
        send(3'd2, 2'd2, 1'b1, 5'd7, 32'hAAAA_AAAA, 32'h0000_2000);
        check("lb_dst", ms_dst_reg, 5'd7);
        load_resp(2, 32'h0080_0000);
        sb_q.push_back({1'b1, 5'd8, exp_load(3'd3, 2'd2, 32'h0080_0000), 32'h0000_2004});
        send(3'd3, 2'd2, 1'b1, 5'd8, 32'hAAAA_AAAA, 32'h0000_2004);
        load_resp(2, 32'h0080_0000);

        // LH sign-extension, and LB on byte 3
        sb_q.push_back({1'b0, 5'd3, exp_load(3'd4, 2'd3, 32'h8001_7FFF), 32'h0000_2008});
        send(3'd4, 2'd3, 1'b0, 5'd3, 32'h0, 32'h0000_2008);
        load_resp(0, 32'h8001_7FFF);
        sb_q.push_back({1'b1, 5'd4, exp_load(3'd2, 2'd3, 32'hF17F_0000), 32'h0000_200C});
        send(3'd2, 2'd3, 1'b1, 5'd4, 32'h0, 32'h0000_200C);
        load_resp(1, 32'hF17F_0000);

        // LHU with WB stalled for two cycles: response parked in HOLD
        sb_q.push_back({1'b1, 5'd10, exp_load(3'd5, 2'd2, 32'hBEEF_0000), 32'h0000_3000});
        send(3'd5, 2'd2, 1'b1, 5'd10, 32'h0, 32'h0000_3000);
        tick();
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        #1;
        check("hold_entry_allowin", ms_allowin, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1357_9BDF;
        check("hold_valid", ms_to_ws_valid, 1'b1);
        check("hold_allowin", ms_allowin, 1'b0);
        check("hold_dst", ms_dst_reg, 5'd10);
        tick();
        ws_allowin = 1'b1;
        #1;
        check("release_valid", ms_to_ws_valid, 1'b1);
        check("release_allowin", ms_allowin, 1'b1);
        tick();
        check("release_gone", ms_to_ws_valid, 1'b0);

        // Back-to-back LW pair, responses on consecutive cycles
        sb_q.push_back({1'b1, 5'd11, 32'h1111_2222, 32'h0000_4000});
        sb_q.push_back({1'b1, 5'd12, 32'h3333_4444, 32'h0000_4004});
        send(3'd1, 2'd3, 1'b1, 5'd11, 32'h0, 32'h0000_4000);
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = {3'd1, 2'd1, 1'b1, 5'd12, 32'h0, 32'h0000_4004};
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_2222;
        #1;
        check("b2b_first_valid", ms_to_ws_valid, 1'b1);
        check("b2b_allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h3333_4444;
        #1;
        check("b2b_second_valid", ms_to_ws_valid, 1'b1);
        check("b2b_second_dst", ms_dst_reg, 5'd12);
        tick();
        data_sram_data_ok = 1'b0;
        check("b2b_done", ms_to_ws_valid, 1'b0);

        // Spurious data_ok while idle
        repeat (2) tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        #1;
        check("spur_valid", ms_to_ws_valid, 1'b0);
        check("spur_allowin", ms_allowin, 1'b1);
        check("spur_dst", ms_dst_reg, 5'd0);
        tick();
        data_sram_data_ok = 1'b0;
        check("spur_after_valid", ms_to_ws_valid, 1'b0);
        check("spur_after_allowin", ms_allowin, 1'b1);

        // Reset while a load waits; a late data_ok is ignored
        send(3'd1, 2'd0, 1'b1, 5'd13, 32'h0, 32'h0000_5000);
        tick();
        resetn = 1'b0;
        #1;
        check("midrst_valid", ms_to_ws_valid, 1'b0);
        check("midrst_allowin", ms_allowin, 1'b1);
        check("midrst_dst", ms_dst_reg, 5'd0);
        check("midrst_bus", ms_to_ws_bus, 70'd0);
        tick();
        resetn = 1'b1;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_7777;
        #1;
        check("late_ok_valid", ms_to_ws_valid, 1'b0);
        check("late_ok_allowin", ms_allowin, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;

        // Pipeline still works after the aborted load
        sb_q.push_back({1'b0, 5'd31, 32'h0BAD_F00D, 32'h0000_6000});
        send(3'd0, 2'd0, 1'b0, 5'd31, 32'h0BAD_F00D, 32'h0000_6000);
        check("post_valid", ms_to_ws_valid, 1'b1);
        tick();

        repeat (2) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
